// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared definitions for the dual-clock FIFO (read and write
//             sides): default geometry, Gray/binary conversion helpers and
//             the output-stage operation encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Default FIFO geometry, shared with the write side.
  localparam int C_ADDRESS_SIZE = 4;
  localparam int C_DATASIZE     = 8;

  // The conversion helpers work on a fixed maximum width. Callers zero-extend
  // their pointer into this width and size-cast the result back down.
  // Zero-extension is harmless in both directions because the leading zeros
  // convert to leading zeros.
  localparam int C_GRAY_W = 32;

  // Operation applied to the one-entry output register on a given cycle.
  typedef enum logic [1:0] {
    OS_HOLD  = 2'd0,
    OS_LOAD  = 2'd1,
    OS_CLEAR = 2'd2
  } out_op_e;

  function automatic logic [C_GRAY_W-1:0] bin2gray(input logic [C_GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [C_GRAY_W-1:0] gray2bin(input logic [C_GRAY_W-1:0] g);
    logic [C_GRAY_W-1:0] b;
    b[C_GRAY_W-1] = g[C_GRAY_W-1];
    for (int i = C_GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_out_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_out_stage
//  Purpose  : One-entry registered valid/ready output stage. A load captures
//             a new word (and may coincide with the consumer taking the old
//             one, giving one word per cycle); a handshake without a load
//             empties the stage; otherwise valid and data hold.
//  Ports    : clk      - clock
//             rst      - synchronous active-high reset (discards held word)
//             load_i   - capture data_i this cycle
//             data_i   - word to capture
//             ready_i  - consumer accepts the held word this cycle
//             valid_o  - stage holds a word
//             data_o   - held word (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_out_stage
  import fifo_pkg::*;
#(
  parameter int DATASIZE = C_DATASIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [DATASIZE-1:0] data_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [DATASIZE-1:0] data_o
);

  logic                valid_q, valid_d;
  logic [DATASIZE-1:0] data_q,  data_d;
  out_op_e             w_op;

  // Load wins over clear: a simultaneous consume and load keeps valid high.
  always_comb begin
    w_op = OS_HOLD;
    if (load_i) begin
      w_op = OS_LOAD;
    end else if (valid_q && ready_i) begin
      w_op = OS_CLEAR;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    case (w_op)
      OS_LOAD: begin
        valid_d = 1'b1;
        data_d  = data_i;
      end
      OS_CLEAR: begin
        valid_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_port.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_port
//  Purpose  : Read-side port of the dual-clock FIFO. Owns the binary/Gray
//             read pointer, the registered empty flag, the RAM read address
//             and an occupancy count, and hands RAM words to the consumer
//             through a one-entry valid/ready output register.
//  Ports    : rclk      - read clock
//             rrst      - synchronous active-high reset
//             rq2_wptr  - Gray write pointer, already synchronized to rclk
//             rdata     - RAM read data (combinational from raddr)
//             raddr     - RAM read address (low bits of binary read pointer)
//             rptr      - registered Gray read pointer for the write domain
//             rempty    - registered empty flag
//             rcount    - registered count of words not yet fetched
//             m_valid   - output stage holds a word
//             m_ready   - consumer accepts the word this cycle
//             m_data    - registered output word
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int ADDRESS_SIZE = C_ADDRESS_SIZE,
  parameter int DATASIZE     = C_DATASIZE
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic [ADDRESS_SIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0]     rdata,
  output logic [ADDRESS_SIZE-1:0] raddr,
  output logic [ADDRESS_SIZE:0]   rptr,
  output logic                    rempty,
  output logic [ADDRESS_SIZE:0]   rcount,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATASIZE-1:0]     m_data
);

  // Pointer width: one extra MSB distinguishes laps around the RAM.
  localparam int C_PW = ADDRESS_SIZE + 1;

  logic [C_PW-1:0] rbin_q,   rbin_d;
  logic [C_PW-1:0] rptr_q,   rptr_d;
  logic [C_PW-1:0] rcount_q, rcount_d;
  logic            rempty_q, rempty_d;
  logic [C_PW-1:0] w_wbin;
  logic            w_fetch;

  // A word is pulled from RAM whenever one is available and the output
  // register is free or being emptied this same cycle.
  assign w_fetch = !rempty_q && (!m_valid || m_ready);

  always_comb begin
    rbin_d   = rbin_q + C_PW'(w_fetch);
    rptr_d   = C_PW'(bin2gray(C_GRAY_W'(rbin_d)));
    w_wbin   = C_PW'(gray2bin(C_GRAY_W'(rq2_wptr)));
    // Comparing against the post-fetch pointer makes empty assert on the
    // same edge that takes the last word, so no extra fetch can follow.
    rempty_d = (rptr_d == rq2_wptr);
    // Modulo-2^(ADDRESS_SIZE+1) difference covers pointer wrap and
    // multi-step write pointer jumps alike.
    rcount_d = w_wbin - rbin_d;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rcount_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rcount_q <= rcount_d;
    end
  end

  fifo_out_stage #(
    .DATASIZE (DATASIZE)
  ) u_out_stage (
    .clk     (rclk),
    .rst     (rrst),
    .load_i  (w_fetch),
    .data_i  (rdata),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data)
  );

  assign raddr  = rbin_q[ADDRESS_SIZE-1:0];
  assign rptr   = rptr_q;
  assign rempty = rempty_q;
  assign rcount = rcount_q;

endmodule
`default_nettype wire
